codec_slave_port: RTL and testbench
===================================

# codec_slave_port

Codec-side end of the audio serial link: receives BCLK, LRCLK and DAC_SDATA from the FPGA codec port master, and drives ADC_SDATA back. Deserializes the play stream into left/right words and serializes record words supplied in parallel. Runs entirely on a local oversampling clock: all link inputs are synchronized and edge-detected, and no logic is clocked by BCLK. Used as the bench/loopback model of the codec and as the slave port for FPGA-to-FPGA audio links.

## Interface
- WIDTH, 24, sample word width; must be ≤ SLOTS-2
- SLOTS, 32, BCLK periods per channel half-frame
- SYNC_STAGES, 2, synchronizer flops on BCLK, LRCLK, DAC_SDATA
- clk  in  1  local clock; must be ≥ 4× master audio_clk, so ≥ 8 clk per BCLK half period
- reset  in  1  asynchronous, active-low
- BCLK  in  1  bit clock from master
- LRCLK  in  1  channel select: 0 = left, 1 = right; changes on BCLK falling edge
- DAC_SDATA  in  1  play data from master
- ADC_SDATA  out  1  record data to master
- LeftAdcData, RightAdcData  in  WIDTH  record words to send
- LeftDacData, RightDacData  out  WIDTH  last received play words
- DacValid  out  1  1-clk pulse: new left/right pair available
- AdcLoad  out  1  1-clk pulse: ADC inputs sampled
- Locked  out  1  frame alignment established
- FrameError  out  1  1-clk pulse: bad half-frame length while locked

## Operation
- Synchronize BCLK, LRCLK and DAC_SDATA through SYNC_STAGES flops. Register the synchronized BCLK and use it to derive single-clk `rise` and `fall` events.
- On each `rise`, sample L = LRCLK_sync.
  - If L ≠ Lprev, this is a boundary: slot := 0 and the previous count is checked (good when the last slot was SLOTS-1).
  - Otherwise slot := slot+1, saturating at 63 (6-bit counter).
- FSM:
  - HUNT: on the first boundary, go to SYNC.
  - SYNC: a good boundary goes to LOCKED; a bad one stays in SYNC.
  - LOCKED: a bad boundary raises FrameError and returns to SYNC.
  - Locked = (state == LOCKED).
- DAC receive, left-justified:
  - On `rise` with slot 0..WIDTH-1, shift DAC_SDATA_sync into the shift register, MSB first.
  - At the `rise` of slot WIDTH-1 while LOCKED, copy the word to LeftDacData (L=0) or RightDacData (L=1).
  - The right copy pulses DacValid one clk after the copy, only if a left word was captured in the same frame.
- ADC transmit, one-slot delay:
  - On `fall`, compute next = (LRCLK_sync ≠ Lprev) ? 0 : slot+1, with channel = LRCLK_sync.
  - ADC_SDATA := held word[channel][WIDTH-next] for next in 1..WIDTH; otherwise 0.
  - ADC_SDATA := 0 whenever not LOCKED.
- ADC holding: on `fall` with next = 0 and LRCLK_sync = 0 (left start), latch both ADC inputs and pulse AdcLoad. Input changes at any other time do not affect the frame being sent.
- Reset values: all outputs 0, state HUNT, slot 0, Lprev 0, holding registers 0.
- Reset asserted mid-frame: immediate clear. Relock needs one boundary to enter SYNC, then one full good half-frame.

## Timing
- Link input edge to internal event: SYNC_STAGES+1 clk.
- BCLK falling edge to ADC_SDATA change: ≤ SYNC_STAGES+2 clk, which is below half a BCLK period at the minimum clk ratio.
- Rise of slot WIDTH-1 to LeftDacData/RightDacData update: 1 clk after the event. DacValid follows 1 clk after RightDacData.
- Lock: the second LRCLK edge after reset, given correct spacing between the first two edges.
- A boundary coinciding with slot saturation counts as bad.

## Test plan
- Reset: hold reset=0 with the link toggling → ADC_SDATA=0, Dac words 0, Locked=0, no pulses.
- Lock and receive: standard master at 4 clk per audio_clk, 4 audio_clk per BCLK, Left=24'hA5A5A5, Right=24'h5A5A5A → Locked at 2nd LRCLK edge; first DacValid with exactly those values; stable thereafter.
- ADC loopback: LeftAdcData=24'h800001, RightAdcData=24'h7FFFFE → master recovers both; ADC_SDATA=0 in slot 0 and slots 25..31.
- ADC inputs changed mid-frame (slot 10, left) → the current frame sends the old words, the next frame the new ones; AdcLoad once per frame.
- Frame error: one half-frame with 31 BCLKs while LOCKED → FrameError 1-clk pulse, Locked 0, no DacValid; relock after the next good half-frame.
- Reset at slot 10 of a left half-frame → outputs cleared immediately; Locked returns after two boundaries; the first DacValid carries correct data.

Source files
------------

// File: rtl/codec_slave_port.sv
// Codec-side slave of the serial audio link: deserializes DAC play words and serializes held ADC record words.
// Latency: link edge to internal event SYNC_STAGES+1 clk; DAC word 1 clk after its last bit; ADC bit <= SYNC_STAGES+2 clk after BCLK fall.
// No backpressure: the link master paces everything; DacValid, AdcLoad and FrameError are single-clk strobes.
module codec_slave_port #(
    parameter int WIDTH       = 24,
    parameter int SLOTS       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BCLK,
    input  logic             LRCLK,
    input  logic             DAC_SDATA,
    output logic             ADC_SDATA,
    input  logic [WIDTH-1:0] LeftAdcData,
    input  logic [WIDTH-1:0] RightAdcData,
    output logic [WIDTH-1:0] LeftDacData,
    output logic [WIDTH-1:0] RightDacData,
    output logic             DacValid,
    output logic             AdcLoad,
    output logic             Locked,
    output logic             FrameError
);
    typedef enum logic [1:0] {ST_HUNT, ST_SYNC, ST_LOCKED} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] bclk_sr, lrclk_sr, dac_sr;
    logic                   bclk_d, bclk_s, lrclk_s, dac_s, rise, fall;
    logic                   lprev, boundary, good, frame_err_d;
    logic [5:0]             slot, slot_inc, cur_slot;
    logic [WIDTH-2:0]       shreg;
    logic [WIDTH-1:0]       rx_word, hold_l, hold_r, tx_word;
    logic                   tx_bit, copy_l, copy_r, left_got, dac_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sr  <= '0;
            lrclk_sr <= '0;
            dac_sr   <= '0;
            bclk_d   <= 1'b0;
        end else begin
            bclk_sr  <= {bclk_sr[SYNC_STAGES-2:0], BCLK};
            lrclk_sr <= {lrclk_sr[SYNC_STAGES-2:0], LRCLK};
            dac_sr   <= {dac_sr[SYNC_STAGES-2:0], DAC_SDATA};
            bclk_d   <= bclk_s;
        end
    end

    assign bclk_s   = bclk_sr[SYNC_STAGES-1];
    assign lrclk_s  = lrclk_sr[SYNC_STAGES-1];
    assign dac_s    = dac_sr[SYNC_STAGES-1];
    assign rise     = bclk_s & ~bclk_d;
    assign fall     = ~bclk_s & bclk_d;
    assign boundary = (lrclk_s != lprev);
    assign slot_inc = (slot == 6'd63) ? slot : slot + 6'd1;
    // Slot index of the bit now on the wire; shared by the receive (rise) and transmit (fall) paths.
    assign cur_slot = boundary ? 6'd0 : slot_inc;
    assign good     = (slot == 6'(SLOTS - 1));
    assign rx_word  = {shreg, dac_s};
    assign copy_l   = rise && (cur_slot == 6'(WIDTH - 1)) && (state_q == ST_LOCKED) && !lrclk_s;
    assign copy_r   = rise && (cur_slot == 6'(WIDTH - 1)) && (state_q == ST_LOCKED) && lrclk_s;
    assign tx_word  = lrclk_s ? hold_r : hold_l;
    assign Locked   = (state_q == ST_LOCKED);

    always_comb begin
        tx_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cur_slot == 6'(WIDTH - i)) tx_bit = tx_word[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_err_d = 1'b0;
        if (rise && boundary) begin
            case (state_q)
                ST_HUNT:   state_d = ST_SYNC;
                ST_SYNC:   if (good) state_d = ST_LOCKED;
                ST_LOCKED: begin
                    if (!good) begin
                        state_d     = ST_SYNC;
                        frame_err_d = 1'b1;
                    end
                end
                default:   state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HUNT;
            FrameError <= 1'b0;
            slot       <= 6'd0;
            lprev      <= 1'b0;
            shreg      <= '0;
        end else begin
            state_q    <= state_d;
            FrameError <= frame_err_d;
            if (rise) begin
                slot  <= cur_slot;
                lprev <= lrclk_s;
                if (cur_slot < 6'(WIDTH)) shreg <= rx_word[WIDTH-2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            LeftDacData  <= '0;
            RightDacData <= '0;
            left_got     <= 1'b0;
            dac_pend     <= 1'b0;
            DacValid     <= 1'b0;
        end else begin
            dac_pend <= copy_r && left_got;
            DacValid <= dac_pend;
            if (copy_l) LeftDacData <= rx_word;
            if (copy_r) RightDacData <= rx_word;
            // A pair is only announced when both halves came from the same locked frame.
            if (state_q != ST_LOCKED) left_got <= 1'b0;
            else if (copy_l)          left_got <= 1'b1;
            else if (copy_r)          left_got <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_l    <= '0;
            hold_r    <= '0;
            AdcLoad   <= 1'b0;
            ADC_SDATA <= 1'b0;
        end else begin
            AdcLoad <= fall && (cur_slot == 6'd0) && !lrclk_s;
            if (fall && (cur_slot == 6'd0) && !lrclk_s) begin
                hold_l <= LeftAdcData;
                hold_r <= RightAdcData;
            end
            if (state_q != ST_LOCKED) ADC_SDATA <= 1'b0;
            else if (fall)            ADC_SDATA <= tx_bit;
        end
    end
endmodule

// File: tb/tb_codec_slave_port.sv
// Bench for codec_slave_port: a behavioural link master plus a frame-level model of lock,
// play-word capture and record-word holding, fed with random words.
module tb_codec_slave_port;
    localparam int WIDTH = 24;
    localparam int SLOTS = 32;
    localparam int HALF  = 8;

    logic             clk = 1'b0;
    logic             reset, BCLK, LRCLK, DAC_SDATA, ADC_SDATA;
    logic [WIDTH-1:0] LeftAdcData, RightAdcData, LeftDacData, RightDacData;
    logic             DacValid, AdcLoad, Locked, FrameError;

    codec_slave_port #(.WIDTH(WIDTH), .SLOTS(SLOTS), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .BCLK(BCLK), .LRCLK(LRCLK), .DAC_SDATA(DAC_SDATA),
        .ADC_SDATA(ADC_SDATA), .LeftAdcData(LeftAdcData), .RightAdcData(RightAdcData),
        .LeftDacData(LeftDacData), .RightDacData(RightDacData), .DacValid(DacValid),
        .AdcLoad(AdcLoad), .Locked(Locked), .FrameError(FrameError)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int n_valid = 0, n_load = 0, n_ferr = 0;
    logic [2*WIDTH-1:0] got_q[$];
    logic [2*WIDTH-1:0] exp_q[$];

    always @(negedge clk) begin
        if (DacValid) begin
            got_q.push_back({LeftDacData, RightDacData});
            n_valid++;
        end
        if (AdcLoad) n_load++;
        if (FrameError) n_ferr++;
    end

    // Frame-level reference: lock needs an earlier edge plus a full-length half-frame.
    bit               m_lr, m_locked, m_lcap;
    int               m_edges, m_len, m_load = 0, m_ferr = 0;
    logic [WIDTH-1:0] m_hold_l, m_hold_r, m_left, m_right, nxt_l, nxt_r;

    task automatic model_reset();
        m_lr = 1'b0; m_locked = 1'b0; m_lcap = 1'b0;
        m_edges = 0; m_len = 0;
        m_hold_l = '0; m_hold_r = '0; m_left = '0; m_right = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic period(input logic lr, input logic d, output logic a);
        BCLK = 1'b0; LRCLK = lr; DAC_SDATA = d;
        repeat (HALF) @(negedge clk);
        a = ADC_SDATA;
        BCLK = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic half(input logic lr, input int nbits, input logic [WIDTH-1:0] dac_w,
                        input int chg_slot, input int rst_slot);
        logic [WIDTH-1:0] rx, exp_w;
        logic             a, d;
        bit               zeros_ok, lk;
        if (lr != m_lr) begin
            if (m_edges >= 1 && m_len == SLOTS) m_locked = 1'b1;
            else begin
                if (m_locked) m_ferr++;
                m_locked = 1'b0;
            end
            m_edges++;
            m_len = 0;
            if (!lr) begin
                m_hold_l = LeftAdcData; m_hold_r = RightAdcData; m_load++;
            end
            m_lr = lr;
        end
        lk = m_locked;
        exp_w = lr ? m_hold_r : m_hold_l;
        rx = '0;
        zeros_ok = 1'b1;
        for (int s = 0; s < nbits; s++) begin
            d = (s < WIDTH) ? dac_w[WIDTH-1-s] : 1'b0;
            if (s == chg_slot) begin
                LeftAdcData = nxt_l; RightAdcData = nxt_r;
            end
            if (s == rst_slot) begin
                BCLK = 1'b0; LRCLK = lr; DAC_SDATA = d;
                reset = 1'b0;
                #1;
                check("midrst_locked", 64'(Locked), 64'(0));
                check("midrst_adc", 64'(ADC_SDATA), 64'(0));
                check("midrst_left", 64'(LeftDacData), 64'(0));
                check("midrst_right", 64'(RightDacData), 64'(0));
                repeat (3) @(negedge clk);
                model_reset();
                reset = 1'b1;
            end
            period(lr, d, a);
            if (s >= 1 && s <= WIDTH) rx[WIDTH-s] = a;
            else if (a !== 1'b0) zeros_ok = 1'b0;
            m_len++;
        end
        if (rst_slot < 0) begin
            if (lk) check("adc_word", 64'(rx), 64'(exp_w));
            else    check("adc_idle", 64'(rx), 64'(0));
            check("adc_zero_slots", 64'(zeros_ok), 64'(1));
        end
        if (rst_slot >= 0 || !lk) m_lcap = 1'b0;
        else if (!lr) begin
            m_left = dac_w; m_lcap = 1'b1;
        end else begin
            m_right = dac_w;
            if (m_lcap) exp_q.push_back({m_left, m_right});
            m_lcap = 1'b0;
        end
        check("locked", 64'(Locked), 64'(m_locked));
        check("left_dac", 64'(LeftDacData), 64'(m_left));
        check("right_dac", 64'(RightDacData), 64'(m_right));
    endtask

    task automatic frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        half(1'b0, SLOTS, l, -1, -1);
        half(1'b1, SLOTS, r, -1, -1);
    endtask

    task automatic release_reset();
        BCLK = 1'b0; LRCLK = 1'b0; DAC_SDATA = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; BCLK = 1'b0; LRCLK = 1'b0; DAC_SDATA = 1'b0;
        LeftAdcData = '0; RightAdcData = '0;
        model_reset();
        repeat (3) @(negedge clk);
        // Link running while reset is held.
        LeftAdcData = 24'hFFFFFF; RightAdcData = 24'hFFFFFF;
        frame(24'($urandom), 24'($urandom));
        check("rst_valid", 64'(n_valid), 64'(0));
        check("rst_load", 64'(n_load), 64'(0));
        check("rst_ferr", 64'(n_ferr), 64'(0));
        release_reset();

        LeftAdcData = 24'h800001; RightAdcData = 24'h7FFFFE;
        for (int f = 0; f < 3; f++) frame(24'hA5A5A5, 24'h5A5A5A);
        for (int f = 0; f < 3; f++) begin
            LeftAdcData = 24'($urandom); RightAdcData = 24'($urandom);
            frame(24'($urandom), 24'($urandom));
        end

        // Record inputs change at slot 10 of a left half.
        nxt_l = 24'($urandom); nxt_r = 24'($urandom);
        half(1'b0, SLOTS, 24'($urandom), 10, -1);
        half(1'b1, SLOTS, 24'($urandom), -1, -1);
        frame(24'($urandom), 24'($urandom));

        // Short left half while locked.
        half(1'b0, SLOTS - 1, 24'($urandom), -1, -1);
        half(1'b1, SLOTS, 24'($urandom), -1, -1);
        check("ferr_count", 64'(n_ferr), 64'(1));
        frame(24'($urandom), 24'($urandom));

        // Reset at slot 10 of a left half, then relock.
        half(1'b0, SLOTS, 24'($urandom), -1, 10);
        half(1'b1, SLOTS, 24'($urandom), -1, -1);
        frame(24'($urandom), 24'($urandom));
        frame(24'($urandom), 24'($urandom));

        check("valid_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("valid_pair", 64'(got_q[i]), 64'(exp_q[i]));
        if (got_q.size() > 0) check("first_pair", 64'(got_q[0]), 64'({24'hA5A5A5, 24'h5A5A5A}));
        else check("first_pair_present", 64'(got_q.size()), 64'(1));
        check("adcload_count", 64'(n_load), 64'(m_load));
        check("frameerr_count", 64'(n_ferr), 64'(m_ferr));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
